// File: rtl/dqn_pkg.sv
// Shared DQN definitions: action encoding, grid-world constants and Q8.8 rewards.
package dqn_pkg;

  localparam int unsigned N_STATE = 9;
  localparam int unsigned N_ACT   = 4;
  localparam int unsigned ST_W    = 4;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_RIGHT = 2'd1,
    ACT_DOWN  = 2'd2,
    ACT_LEFT  = 2'd3
  } act_e;

  localparam logic [15:0] R_GOAL_Q88 = 16'h0100;  // +1.0
  localparam logic [15:0] R_HOLE_Q88 = 16'hFF00;  // -1.0
  localparam logic [15:0] R_STEP_Q88 = 16'hFFF0;  // -0.0625
  localparam logic [15:0] R_WALL_Q88 = 16'hFFC0;  // -0.25

  typedef enum logic [2:0] {
    EP_INIT,
    WAIT_ACT,
    MOVE,
    RESP,
    COMMIT
  } env_state_e;

endpackage

// File: rtl/gridworld_move.sv
// Combinational move resolver: splits the state into row/col, applies the action,
// and flags moves that would leave the grid.
module gridworld_move
  import dqn_pkg::*;
#(
  parameter int unsigned GRID_W = 3,
  parameter int unsigned GRID_H = 3
) (
  input  logic [ST_W-1:0] st,
  input  logic [1:0]      act,
  output logic [ST_W-1:0] cand_st,
  output logic            wall_hit
);

  int unsigned row;
  int unsigned col;
  int unsigned cand;

  // Resolve the candidate cell from the row/col split of the current state
  always_comb begin
    row      = 32'(st) / GRID_W;
    col      = 32'(st) % GRID_W;
    wall_hit = 1'b0;
    cand     = 32'(st);
    case (act)
      ACT_UP:    if (row == 0)          wall_hit = 1'b1; else cand = 32'(st) - GRID_W;
      ACT_RIGHT: if (col == GRID_W - 1) wall_hit = 1'b1; else cand = 32'(st) + 1;
      ACT_DOWN:  if (row == GRID_H - 1) wall_hit = 1'b1; else cand = 32'(st) + GRID_W;
      ACT_LEFT:  if (col == 0)          wall_hit = 1'b1; else cand = 32'(st) - 1;
      default:   wall_hit = 1'b0;
    endcase
    cand_st = wall_hit ? st : ST_W'(cand);
  end

endmodule

// File: rtl/gridworld_env.sv
// Grid-world environment responder: accepts an action, returns next state,
// reward and done, and tracks per-episode step and completed-episode counters.
module gridworld_env
  import dqn_pkg::*;
#(
  parameter int unsigned GRID_W    = 3,
  parameter int unsigned GRID_H    = 3,
  parameter int unsigned START_ST  = 0,
  parameter int unsigned GOAL_ST   = 8,
  parameter int unsigned HOLE_ST   = 4,
  parameter int unsigned MAX_STEPS = 32,
  parameter int unsigned RW        = 16,
  parameter logic [RW-1:0] R_GOAL  = RW'(R_GOAL_Q88),
  parameter logic [RW-1:0] R_HOLE  = RW'(R_HOLE_Q88),
  parameter logic [RW-1:0] R_STEP  = RW'(R_STEP_Q88),
  parameter logic [RW-1:0] R_WALL  = RW'(R_WALL_Q88)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         act,
  input  logic               act_valid,
  output logic               act_ready,
  output logic [ST_W-1:0]    st,
  output logic [N_STATE-1:0] st_onehot,
  output logic [ST_W-1:0]    st1,
  output logic [RW-1:0]      reward,
  output logic               done,
  output logic               obs_valid,
  input  logic               obs_ready,
  output logic               ep_start,
  output logic [7:0]         step,
  output logic [15:0]        episode
);

  env_state_e        state_q;
  logic [1:0]        act_q;
  logic [ST_W-1:0]   st_q, st1_q;
  logic [RW-1:0]     reward_q;
  logic              done_q, act_ready_q, obs_valid_q, ep_start_q;
  logic [7:0]        step_q;
  logic [15:0]       episode_q;

  logic [ST_W-1:0]   cand_st;
  logic              wall_hit;
  logic [ST_W-1:0]   st1_d;
  logic [RW-1:0]     reward_d;
  logic              done_d;

  gridworld_move #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H)
  ) u_move (
    .st       (st_q),
    .act      (act_q),
    .cand_st  (cand_st),
    .wall_hit (wall_hit)
  );

  // Observation to be latched in MOVE; truncation keeps the move/wall reward
  always_comb begin
    st1_d    = cand_st;
    reward_d = R_STEP;
    if (wall_hit)                          reward_d = R_WALL;
    else if (cand_st == ST_W'(GOAL_ST))    reward_d = R_GOAL;
    else if (cand_st == ST_W'(HOLE_ST))    reward_d = R_HOLE;
    done_d = (st1_d == ST_W'(GOAL_ST)) || (st1_d == ST_W'(HOLE_ST)) ||
             (step_q + 8'd1 == 8'(MAX_STEPS));
  end

  // Episode FSM with registered handshake outputs and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EP_INIT;
      act_q       <= '0;
      st_q        <= ST_W'(START_ST);
      st1_q       <= '0;
      reward_q    <= '0;
      done_q      <= 1'b0;
      act_ready_q <= 1'b0;
      obs_valid_q <= 1'b0;
      ep_start_q  <= 1'b0;
      step_q      <= '0;
      episode_q   <= '0;
    end else begin
      ep_start_q <= 1'b0;
      unique case (state_q)
        EP_INIT: begin
          st_q        <= ST_W'(START_ST);
          step_q      <= '0;
          ep_start_q  <= 1'b1;
          act_ready_q <= 1'b1;
          state_q     <= WAIT_ACT;
        end
        WAIT_ACT: begin
          if (act_valid && act_ready_q) begin
            act_q       <= act;
            act_ready_q <= 1'b0;
            state_q     <= MOVE;
          end
        end
        MOVE: begin
          st1_q       <= st1_d;
          reward_q    <= reward_d;
          done_q      <= done_d;
          obs_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (obs_ready) begin
            obs_valid_q <= 1'b0;
            state_q     <= COMMIT;
          end
        end
        COMMIT: begin
          st_q   <= st1_q;
          step_q <= step_q + 8'd1;
          if (done_q) begin
            episode_q <= episode_q + 16'd1;
            state_q   <= EP_INIT;
          end else begin
            act_ready_q <= 1'b1;
            state_q     <= WAIT_ACT;
          end
        end
        default: state_q <= EP_INIT;
      endcase
    end
  end

  assign act_ready = act_ready_q;
  assign st        = st_q;
  assign st_onehot = N_STATE'(1) << st_q;
  assign st1       = st1_q;
  assign reward    = reward_q;
  assign done      = done_q;
  assign obs_valid = obs_valid_q;
  assign ep_start  = ep_start_q;
  assign step      = step_q;
  assign episode   = episode_q;

endmodule

// File: tb/tb_gridworld_env.sv
// Directed bench for gridworld_env: main instance with default parameters plus a
// short-episode instance (MAX_STEPS=4) held in reset until its truncation scenario.
module tb_gridworld_env;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_t = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  act = '0;
  logic        act_valid = 1'b0;
  logic        obs_ready = 1'b0;

  logic        ar, dn, ov, eps;
  logic [3:0]  st, st1;
  logic [8:0]  oh;
  logic [15:0] rw, epi;
  logic [7:0]  stp;

  logic        t_ar, t_dn, t_ov, t_eps;
  logic [3:0]  t_st, t_st1;
  logic [8:0]  t_oh;
  logic [15:0] t_rw, t_epi;
  logic [7:0]  t_stp;

  logic        m_ar, m_dn, m_ov, m_eps;
  logic [3:0]  m_st, m_st1;
  logic [8:0]  m_oh;
  logic [15:0] m_rw, m_epi;
  logic [7:0]  m_stp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gridworld_env dut (
    .clk(clk), .rst(rst), .act(act), .act_valid(act_valid), .act_ready(ar),
    .st(st), .st_onehot(oh), .st1(st1), .reward(rw), .done(dn),
    .obs_valid(ov), .obs_ready(obs_ready), .ep_start(eps), .step(stp), .episode(epi)
  );

  gridworld_env #(.MAX_STEPS(4)) dut_t (
    .clk(clk), .rst(rst_t), .act(act), .act_valid(act_valid), .act_ready(t_ar),
    .st(t_st), .st_onehot(t_oh), .st1(t_st1), .reward(t_rw), .done(t_dn),
    .obs_valid(t_ov), .obs_ready(obs_ready), .ep_start(t_eps), .step(t_stp), .episode(t_epi)
  );

  assign m_ar  = sel ? t_ar  : ar;
  assign m_dn  = sel ? t_dn  : dn;
  assign m_ov  = sel ? t_ov  : ov;
  assign m_eps = sel ? t_eps : eps;
  assign m_st  = sel ? t_st  : st;
  assign m_st1 = sel ? t_st1 : st1;
  assign m_oh  = sel ? t_oh  : oh;
  assign m_rw  = sel ? t_rw  : rw;
  assign m_epi = sel ? t_epi : epi;
  assign m_stp = sel ? t_stp : stp;

  // Leaves the caller at a negedge with act_ready high (or after a timeout)
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (m_ar !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_ar !== 1'b1) begin
      total++; bad++;
      $display("FAIL ready_timeout act_ready=%b want=1", m_ar);
    end
  endtask

  task automatic send_act(input logic [1:0] a);
    wait_ready();
    act = a;
    act_valid = 1'b1;
    @(posedge clk);
    #1 act_valid = 1'b0;
  endtask

  // Called just after the accepting edge; lat counts edges from accept to obs_valid
  task automatic wait_obs(output int lat, output logic [3:0] s, output logic [3:0] s1,
                          output logic [15:0] r, output logic d, output logic [8:0] o);
    lat = 1;
    forever begin
      @(negedge clk);
      if (m_ov === 1'b1 || lat > 40) break;
      @(posedge clk);
      lat++;
    end
    if (m_ov !== 1'b1) begin
      total++; bad++;
      $display("FAIL obs_timeout obs_valid=%b want=1", m_ov);
    end
    s = m_st; s1 = m_st1; r = m_rw; d = m_dn; o = m_oh;
  endtask

  task automatic take_obs();
    obs_ready = 1'b1;
    @(posedge clk);
    #1 obs_ready = 1'b0;
  endtask

  task automatic count_ep_start(output int pulses);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_eps === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    int p;
    logic [59:0] got;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    got = {m_st, m_st1, m_rw, m_dn, m_ar, m_ov, m_eps, m_stp, m_epi, 8'h00};
    total++;
    if (got !== 60'd0) begin bad++; $display("FAIL reset_values got=%h want=0", got); end
    total++;
    if (m_oh !== 9'h001) begin bad++; $display("FAIL reset_onehot got=%h want=001", m_oh); end
    rst = 1'b1;
    count_ep_start(p);
    total++;
    if (p != 1) begin bad++; $display("FAIL reset_ep_start pulses=%0d want=1", p); end
    total++;
    if (m_ar !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", m_ar); end
  endtask

  task automatic test_wall();
    int lat; logic [3:0] s, s1; logic [15:0] r; logic d; logic [8:0] o;
    send_act(2'd0);
    wait_obs(lat, s, s1, r, d, o);
    total++;
    if (lat != 2) begin bad++; $display("FAIL wall_latency got=%0d want=2", lat); end
    total++;
    if ({s, s1} !== 8'h00) begin bad++; $display("FAIL wall_states got=%h want=00", {s, s1}); end
    total++;
    if (r !== 16'hFFC0) begin bad++; $display("FAIL wall_reward got=%h want=ffc0", r); end
    total++;
    if (d !== 1'b0) begin bad++; $display("FAIL wall_done got=%b want=0", d); end
    take_obs();
    wait_ready();
    total++;
    if (m_stp !== 8'd1) begin bad++; $display("FAIL wall_step got=%0d want=1", m_stp); end
  endtask

  task automatic test_goal_path();
    logic [1:0] acts [4]  = '{2'd1, 2'd1, 2'd2, 2'd2};
    logic [3:0] ex_s [4]  = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic [3:0] ex_s1 [4] = '{4'd1, 4'd2, 4'd5, 4'd8};
    int lat; logic [3:0] s, s1; logic [15:0] r, er; logic d; logic [8:0] o, eo;
    for (int i = 0; i < 4; i++) begin
      send_act(acts[i]);
      wait_obs(lat, s, s1, r, d, o);
      er = (i == 3) ? 16'h0100 : 16'hFFF0;
      eo = 9'd1 << ex_s[i];
      total++;
      if (s !== ex_s[i] || s1 !== ex_s1[i])
        begin bad++; $display("FAIL goal_states[%0d] got=%0d,%0d want=%0d,%0d", i, s, s1, ex_s[i], ex_s1[i]); end
      total++;
      if (o !== eo) begin bad++; $display("FAIL goal_onehot[%0d] got=%h want=%h", i, o, eo); end
      total++;
      if (r !== er) begin bad++; $display("FAIL goal_reward[%0d] got=%h want=%h", i, r, er); end
      total++;
      if (d !== (i == 3)) begin bad++; $display("FAIL goal_done[%0d] got=%b want=%b", i, d, (i == 3)); end
      take_obs();
    end
    wait_ready();
    total++;
    if ({m_epi, m_st, m_stp} !== {16'd1, 4'd0, 8'd0})
      begin bad++; $display("FAIL goal_restart got=ep%0d st%0d step%0d want=ep1 st0 step0", m_epi, m_st, m_stp); end
  endtask

  task automatic test_hole();
    int lat; logic [3:0] s, s1; logic [15:0] r; logic d; logic [8:0] o;
    send_act(2'd2);
    wait_obs(lat, s, s1, r, d, o);
    total++;
    if ({s1, r, d} !== {4'd3, 16'hFFF0, 1'b0})
      begin bad++; $display("FAIL hole_first got=%0d,%h,%b want=3,fff0,0", s1, r, d); end
    take_obs();
    send_act(2'd1);
    wait_obs(lat, s, s1, r, d, o);
    total++;
    if ({s1, r, d} !== {4'd4, 16'hFF00, 1'b1})
      begin bad++; $display("FAIL hole_enter got=%0d,%h,%b want=4,ff00,1", s1, r, d); end
    take_obs();
    wait_ready();
    total++;
    if ({m_epi, m_st, m_stp} !== {16'd2, 4'd0, 8'd0})
      begin bad++; $display("FAIL hole_restart got=ep%0d st%0d step%0d want=ep2 st0 step0", m_epi, m_st, m_stp); end
  endtask

  task automatic test_backpressure();
    int lat; logic [3:0] s, s1; logic [15:0] r; logic d; logic [8:0] o;
    logic stable = 1'b1, ar_low = 1'b1, step_hold = 1'b1;
    logic [7:0] step0;
    wait_ready();
    act = 2'd1;
    act_valid = 1'b1;
    @(posedge clk);
    #1 act = 2'd3;
    wait_obs(lat, s, s1, r, d, o);
    step0 = m_stp;
    repeat (10) begin
      @(negedge clk);
      if (m_st !== s || m_st1 !== s1 || m_rw !== r || m_dn !== d || m_ov !== 1'b1) stable = 1'b0;
      if (m_ar !== 1'b0) ar_low = 1'b0;
      if (m_stp !== step0) step_hold = 1'b0;
    end
    total++;
    if (stable !== 1'b1 || s1 !== 4'd1) begin bad++; $display("FAIL bp_stable got=%b st1=%0d want=1 st1=1", stable, s1); end
    total++;
    if (ar_low !== 1'b1) begin bad++; $display("FAIL bp_ready_low got=%b want=1", ar_low); end
    total++;
    if (step_hold !== 1'b1) begin bad++; $display("FAIL bp_step_hold got=%b want=1", step_hold); end
    take_obs();
    @(negedge clk);
    total++;
    if (m_ar !== 1'b0) begin bad++; $display("FAIL bp_commit_ready got=%b want=0", m_ar); end
    @(negedge clk);
    total++;
    if (m_ar !== 1'b1) begin bad++; $display("FAIL bp_reopen_ready got=%b want=1", m_ar); end
    @(posedge clk);
    #1 act_valid = 1'b0;
    wait_obs(lat, s, s1, r, d, o);
    total++;
    if ({lat[3:0], s, s1} !== {4'd2, 4'd1, 4'd0})
      begin bad++; $display("FAIL bp_second got=lat%0d %0d->%0d want=lat2 1->0", lat, s, s1); end
    take_obs();
    wait_ready();
    total++;
    if ({m_st, m_stp} !== {4'd0, 8'd2}) begin bad++; $display("FAIL bp_step got=st%0d step%0d want=st0 step2", m_st, m_stp); end
  endtask

  task automatic test_reset_mid_resp();
    int lat, p; logic [3:0] s, s1; logic [15:0] r; logic d; logic [8:0] o;
    logic [59:0] got;
    send_act(2'd2);
    wait_obs(lat, s, s1, r, d, o);
    rst = 1'b0;
    #1;
    got = {m_st, m_st1, m_rw, m_dn, m_ar, m_ov, m_eps, m_stp, m_epi, 8'h00};
    total++;
    if (got !== 60'd0) begin bad++; $display("FAIL midreset_values got=%h want=0", got); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    count_ep_start(p);
    total++;
    if (p != 1) begin bad++; $display("FAIL midreset_ep_start pulses=%0d want=1", p); end
    total++;
    if ({m_st, m_ar} !== {4'd0, 1'b1}) begin bad++; $display("FAIL midreset_ready got=st%0d rdy%b want=st0 rdy1", m_st, m_ar); end
  endtask

  task automatic test_truncation();
    int lat; logic [3:0] s, s1, es1; logic [15:0] r; logic d; logic [8:0] o;
    sel = 1'b1;
    @(negedge clk);
    rst_t = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_act((i % 2 == 0) ? 2'd1 : 2'd3);
      wait_obs(lat, s, s1, r, d, o);
      es1 = (i % 2 == 0) ? 4'd1 : 4'd0;
      total++;
      if ({s1, r, d} !== {es1, 16'hFFF0, (i == 3)})
        begin bad++; $display("FAIL trunc[%0d] got=%0d,%h,%b want=%0d,fff0,%b", i, s1, r, d, es1, (i == 3)); end
      take_obs();
    end
    wait_ready();
    total++;
    if ({m_epi, m_stp} !== {16'd1, 8'd0}) begin bad++; $display("FAIL trunc_restart got=ep%0d step%0d want=ep1 step0", m_epi, m_stp); end
  endtask

  initial begin
    test_reset();
    test_wall();
    test_goal_path();
    test_hole();
    test_backpressure();
    test_reset_mid_resp();
    test_truncation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
